hawk_burst_wr_mngr: RTL and testbench
=====================================

HAWK_BURST_WR_MNGR -- requirements
Module: hawk_burst_wr_mngr

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the write address width in bits.
REQ-002 SHALL have parameter LINE_BYTES, default 64, meaning the bytes per write beat (cacheline).
REQ-003 SHALL have parameter MAX_LINES, default 64, meaning the maximum number of data lines per command.
REQ-004 SHALL have parameter MD_BYTES, default 50, meaning the metadata size in bytes.
REQ-005 SHALL have parameter PTR_BYTES, default 12, meaning the pointer field size in bytes; MD_BYTES+PTR_BYTES<=LINE_BYTES.
REQ-006 Ports (name, direction, width, meaning):
- clk_i  in  1  the single clock.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_op_i  in  1  0=DATA (lines, optionally plus metadata), 1=MD_ONLY.
- cmd_addr_i  in  ADDR_W  base address of the data lines.
- cmd_nlines_i  in  $clog2(MAX_LINES+1)  number of data lines.
- cmd_md_en_i  in  1  append a metadata line after a DATA op.
- cmd_md_addr_i  in  ADDR_W  address of the metadata line.
- cmd_md_i  in  MD_BYTES*8  metadata payload.
- cmd_ptrs_i  in  PTR_BYTES*8  pointer payload.
- dat_valid_i / dat_ready_o  in/out  1  line-data stream handshake.
- dat_i  in  LINE_BYTES*8  line data.
- wr_valid_o / wr_ready_i  out/in  1  write request handshake.
- wr_addr_o  out  ADDR_W  write address.
- wr_data_o  out  LINE_BYTES*8  write data.
- wr_strb_o  out  LINE_BYTES  byte strobes.
- wr_resp_i  in  1  one write completion per pulse.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- done_o  out  1  single-cycle completion pulse.
- err_o  out  1  sticky protocol error.

Function
REQ-007 FSM states SHALL be IDLE, DATA, MD, DRAIN and DONE; cmd_ready_o=1 only in IDLE.
REQ-008 On a cmd accept in IDLE, all cmd fields SHALL be latched and the next state SHALL be:
- DATA if op=DATA and nlines>0;
- otherwise MD if op=MD_ONLY, or if md_en=1;
- otherwise DRAIN.
REQ-009 In DATA, dat_ready_o SHALL equal (lines_left>0)&&(!wr_valid_o||wr_ready_i); each dat handshake SHALL load the output register in the same cycle, enabling 1 beat/cycle throughput.
REQ-010 Line k (0-based) SHALL use wr_addr_o=(base & ~(LINE_BYTES-1))+k*LINE_BYTES modulo 2^ADDR_W, wr_data_o=dat_i, and wr_strb_o all ones.
REQ-011 After the last line is loaded, DATA SHALL go to MD if md_en=1, else to DRAIN.
REQ-012 MD SHALL issue exactly one beat at md_addr, with data = zeros above, md_i above, and ptrs_i in the low PTR_BYTES.
- DATA op: strobes SHALL cover bytes [MD_BYTES+PTR_BYTES-1:0].
- MD_ONLY op: strobes SHALL cover only bytes [MD_BYTES+PTR_BYTES-1:PTR_BYTES], so pointers are preserved.
- The FSM SHALL move to DRAIN once the beat is loaded.
REQ-013 Once wr_valid_o is asserted, wr_valid_o, wr_addr_o, wr_data_o and wr_strb_o SHALL stay stable until wr_ready_i is high.
REQ-014 The outstanding counter (width $clog2(MAX_LINES+2)) SHALL behave as follows:
- +1 on each wr handshake;
- -1 on each wr_resp_i;
- unchanged when both occur in the same cycle.
REQ-015 DRAIN SHALL go to DONE when wr_valid_o=0 and outstanding=0 (counting a resp arriving in that cycle); DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-016 A wr_resp_i with outstanding=0 SHALL be ignored for counting and SHALL set err_o, which stays set until reset.
REQ-017 A new cmd SHALL NOT be accepted until done_o has pulsed; cmd_valid_i outside IDLE SHALL have no effect.
REQ-018 DATA with nlines=0 and md_en=0 SHALL produce no writes and SHALL pulse done_o 2 cycles after the cmd accept.

Reset
REQ-019 rst_i high SHALL asynchronously force the following:
- state=IDLE;
- counters=0;
- wr_valid_o=0, dat_ready_o=0, done_o=0, busy_o=0, err_o=0;
- cmd_ready_o=1 after release;
- wr_addr_o, wr_data_o and wr_strb_o=0.
REQ-020 A reset asserted mid-command SHALL discard the command and any pending beat with no done_o pulse; responses arriving after reset release with outstanding=0 SHALL set err_o.

Structure
REQ-021 The op encoding, the state enum and the cmd/write packet structs SHALL reside in hacd_pkg, parametrised widths being derived locally.
REQ-022 The single-entry valid/ready output register SHALL be a sub-module named hawk_wr_outreg; the FSM and counters SHALL stay in the top module.

Verification
REQ-023 The bench SHALL cover all of the following:
- DATA, nlines=64, addr=0x1000, md_en=1, wr_ready_i=1, resp 3 cycles later: 65 writes at 0x1000..0x1FC0 then md_addr, final strobe = 62 low bytes, one done_o.
- MD_ONLY, md_addr=0x2000: one write, strobe bytes [61:12] only, data[95:0]=0.
- DATA, nlines=4, random wr_ready_i/dat_valid_i stalls: payload and address stable while stalled, exactly 4 beats in order.
- Base address 0xFFFF...FFC0, nlines=2: second address wraps to 0x0.
- rst_i pulsed after the 2nd of 8 beats: outputs idle, no done_o; a resp then sets err_o.
- wr handshake and wr_resp_i in the same cycle: outstanding count unchanged, done_o timing correct.

Source files
------------

// File: rtl/hawk_burst_wr_mngr_pkg.sv
// Shared op encoding, FSM states and command control record for the burst write manager.
package hacd_pkg;

    typedef enum logic {
        OP_DATA    = 1'b0,
        OP_MD_ONLY = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_MD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        op_e  op;
        logic md_en;
    } cmd_ctl_t;

endpackage

// File: rtl/hawk_burst_wr_mngr_if.sv
// Command, line-data, write-request and status signals of the burst write manager.
interface hawk_burst_wr_mngr_if #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int MAX_LINES  = 64,
    parameter int MD_BYTES   = 50,
    parameter int PTR_BYTES  = 12
);
    localparam int NL_W = $clog2(MAX_LINES + 1);

    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_op_i;
    logic [ADDR_W-1:0]       cmd_addr_i;
    logic [NL_W-1:0]         cmd_nlines_i;
    logic                    cmd_md_en_i;
    logic [ADDR_W-1:0]       cmd_md_addr_i;
    logic [MD_BYTES*8-1:0]   cmd_md_i;
    logic [PTR_BYTES*8-1:0]  cmd_ptrs_i;
    logic                    dat_valid_i;
    logic                    dat_ready_o;
    logic [LINE_BYTES*8-1:0] dat_i;
    logic                    wr_valid_o;
    logic                    wr_ready_i;
    logic [ADDR_W-1:0]       wr_addr_o;
    logic [LINE_BYTES*8-1:0] wr_data_o;
    logic [LINE_BYTES-1:0]   wr_strb_o;
    logic                    wr_resp_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_nlines_i, cmd_md_en_i,
               cmd_md_addr_i, cmd_md_i, cmd_ptrs_i, dat_valid_i, dat_i,
               wr_ready_i, wr_resp_i,
        output cmd_ready_o, dat_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
               wr_strb_o, busy_o, done_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_nlines_i, cmd_md_en_i,
               cmd_md_addr_i, cmd_md_i, cmd_ptrs_i, dat_valid_i, dat_i,
               wr_ready_i, wr_resp_i,
        input  cmd_ready_o, dat_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
               wr_strb_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/hawk_burst_wr_mngr_outreg.sv
// Single-entry write-request register: a load is visible next cycle and held until i_rdy;
// o_free lets a new beat be loaded in the same cycle the current one drains.
module hawk_wr_outreg #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    i_load,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [LINE_BYTES*8-1:0] i_data,
    input  logic [LINE_BYTES-1:0]   i_strb,
    input  logic                    i_rdy,
    output logic                    o_vld,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [LINE_BYTES*8-1:0] o_data,
    output logic [LINE_BYTES-1:0]   o_strb,
    output logic                    o_free
);
    logic                    r_vld;
    logic [ADDR_W-1:0]       r_addr;
    logic [LINE_BYTES*8-1:0] r_data;
    logic [LINE_BYTES-1:0]   r_strb;

    assign o_free = !r_vld || i_rdy;
    assign o_vld  = r_vld;
    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_strb = r_strb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
            r_strb <= i_strb;
        end else if (i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/hawk_burst_wr_mngr.sv
// Turns a command into line writes plus an optional metadata write, then waits for all
// responses before pulsing done_o; streams 1 beat/cycle, stalls on wr_ready_i backpressure.
module hawk_burst_wr_mngr
    import hacd_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int MAX_LINES  = 64,
    parameter int MD_BYTES   = 50,
    parameter int PTR_BYTES  = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hawk_burst_wr_mngr_if.slave bus
);
    localparam int NL_W     = $clog2(MAX_LINES + 1);
    localparam int OUT_W    = $clog2(MAX_LINES + 2);
    localparam int LB_W     = $clog2(LINE_BYTES);
    localparam int MP_BYTES = MD_BYTES + PTR_BYTES;

    typedef struct packed {
        cmd_ctl_t                ctl;
        logic [ADDR_W-1:0]       md_addr;
        logic [MD_BYTES*8-1:0]   md;
        logic [PTR_BYTES*8-1:0]  ptrs;
    } cmd_pkt_t;

    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic [LINE_BYTES*8-1:0] data;
        logic [LINE_BYTES-1:0]   strb;
    } wr_pkt_t;

    state_e            r_state;
    cmd_pkt_t          r_cmd;
    logic [NL_W-1:0]   r_lines_left;
    logic [ADDR_W-1:0] r_line_addr;
    logic [OUT_W-1:0]  r_outstanding;
    logic              r_done;
    logic              r_err;

    logic    w_free, w_wr_vld, w_dat_hs, w_md_load, w_load;
    logic    w_wr_hs, w_resp_cnt, w_resp_err, w_drained;
    wr_pkt_t w_md_pkt, w_in_pkt;

    assign bus.cmd_ready_o = (r_state == ST_IDLE);
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;
    assign bus.wr_valid_o  = w_wr_vld;
    assign bus.dat_ready_o = (r_state == ST_DATA) && (r_lines_left != '0) && w_free;

    assign w_dat_hs   = bus.dat_ready_o && bus.dat_valid_i;
    assign w_md_load  = (r_state == ST_MD) && w_free;
    assign w_load     = w_dat_hs || w_md_load;
    assign w_wr_hs    = w_wr_vld && bus.wr_ready_i;
    // A response with nothing outstanding is a protocol error and must not underflow the count.
    assign w_resp_cnt = bus.wr_resp_i && (r_outstanding != '0);
    assign w_resp_err = bus.wr_resp_i && (r_outstanding == '0);
    assign w_drained  = !w_wr_vld &&
                        ((r_outstanding == '0) || ((r_outstanding == OUT_W'(1)) && w_resp_cnt));

    // MD_ONLY leaves the pointer bytes unstrobed so the existing pointers survive.
    always_comb begin
        w_md_pkt      = '0;
        w_md_pkt.addr = r_cmd.md_addr;
        w_md_pkt.data[MP_BYTES*8-1:0] = {r_cmd.md, r_cmd.ptrs};
        for (int i = 0; i < LINE_BYTES; i++) begin
            w_md_pkt.strb[i] = (i < MP_BYTES) && ((r_cmd.ctl.op == OP_DATA) || (i >= PTR_BYTES));
        end
    end

    always_comb begin
        w_in_pkt = w_md_pkt;
        if (r_state == ST_DATA) begin
            w_in_pkt.addr = r_line_addr;
            w_in_pkt.data = bus.dat_i;
            w_in_pkt.strb = '1;
        end
    end

    hawk_wr_outreg #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_outreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_load),
        .i_addr (w_in_pkt.addr),
        .i_data (w_in_pkt.data),
        .i_strb (w_in_pkt.strb),
        .i_rdy  (bus.wr_ready_i),
        .o_vld  (w_wr_vld),
        .o_addr (bus.wr_addr_o),
        .o_data (bus.wr_data_o),
        .o_strb (bus.wr_strb_o),
        .o_free (w_free)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_lines_left  <= '0;
            r_line_addr   <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_resp_err) r_err <= 1'b1;

            case ({w_wr_hs, w_resp_cnt})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_cmd.ctl.op    <= op_e'(bus.cmd_op_i);
                        r_cmd.ctl.md_en <= bus.cmd_md_en_i;
                        r_cmd.md_addr   <= bus.cmd_md_addr_i;
                        r_cmd.md        <= bus.cmd_md_i;
                        r_cmd.ptrs      <= bus.cmd_ptrs_i;
                        r_lines_left    <= bus.cmd_nlines_i;
                        r_line_addr     <= {bus.cmd_addr_i[ADDR_W-1:LB_W], {LB_W{1'b0}}};
                        if ((op_e'(bus.cmd_op_i) == OP_DATA) && (bus.cmd_nlines_i != '0))
                            r_state <= ST_DATA;
                        else if ((op_e'(bus.cmd_op_i) == OP_MD_ONLY) || bus.cmd_md_en_i)
                            r_state <= ST_MD;
                        else
                            r_state <= ST_DRAIN;
                    end
                end
                ST_DATA: begin
                    if (w_dat_hs) begin
                        r_lines_left <= r_lines_left - NL_W'(1);
                        r_line_addr  <= r_line_addr + ADDR_W'(LINE_BYTES);
                        if (r_lines_left == NL_W'(1))
                            r_state <= r_cmd.ctl.md_en ? ST_MD : ST_DRAIN;
                    end
                end
                ST_MD: begin
                    if (w_free) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hawk_burst_wr_mngr.sv
// Randomized bench for hawk_burst_wr_mngr against a queue-based write/response model.
module tb_hawk_burst_wr_mngr;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hawk_burst_wr_mngr_if bus ();

    hawk_burst_wr_mngr dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    wr_t          exp_q[$];
    logic [511:0] dat_q[$];
    int           resp_q[$];
    logic [63:0]  wr_addr_log[$];
    logic [511:0] last_wdata;
    int  last_sched = -1;
    int  last_resp_cyc = 0;
    int  acc_cyc = 0;
    int  acc_cnt = 0;
    int  done_cnt = 0;
    int  hs_cnt = 0;
    int  cur_nw = 0;
    int  model_out = 0;
    int  n_both = 0;
    int  rd_min = 3;
    int  rd_max = 3;
    logic stall = 1'b0;
    logic dat_hs_last = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_both = 1'b0;
    logic [127:0] prev_as;
    logic [511:0] prev_data;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Input drivers for the line stream, write backpressure and responses.
    initial begin
        bus.dat_valid_i = 1'b0;
        bus.dat_i       = '0;
        bus.wr_ready_i  = 1'b0;
        bus.wr_resp_i   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!(bus.dat_valid_i && !dat_hs_last && dat_q.size() > 0)) begin
                if (dat_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
                    bus.dat_valid_i = 1'b1;
                    bus.dat_i       = dat_q[0];
                end else begin
                    bus.dat_valid_i = 1'b0;
                end
            end
            bus.wr_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wr_resp_i  = 1'b0;
            if (resp_q.size() > 0 && resp_q[0] <= cyc) begin
                bus.wr_resp_i = 1'b1;
                resp_q.delete(0);
            end
        end
    end

    // Monitor: sampled mid-cycle, after all inputs and combinational outputs settle.
    always @(negedge clk) begin
        logic hs, resp, resp_counts;
        int   t;
        if (rst) begin
            dat_hs_last = 1'b0;
            prev_stall  = 1'b0;
            prev_both   = 1'b0;
        end else begin
            hs   = bus.wr_valid_o && bus.wr_ready_i;
            resp = bus.wr_resp_i;
            dat_hs_last = bus.dat_valid_i && bus.dat_ready_o;
            if (dat_hs_last && dat_q.size() > 0) dat_q.delete(0);

            if (prev_stall) begin
                chk("hold_vld", 640'(bus.wr_valid_o), 640'(1));
                chk("hold_addr_strb", 640'({bus.wr_addr_o, bus.wr_strb_o}), 640'(prev_as));
                chk("hold_data", 640'(bus.wr_data_o), 640'(prev_data));
            end
            prev_stall = bus.wr_valid_o && !bus.wr_ready_i;
            prev_as    = {bus.wr_addr_o, bus.wr_strb_o};
            prev_data  = bus.wr_data_o;

            if (hs) begin
                hs_cnt++;
                wr_addr_log.push_back(bus.wr_addr_o);
                last_wdata = bus.wr_data_o;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 640'(hs_cnt), 640'(cur_nw));
                end else begin
                    chk("wr_addr", 640'(bus.wr_addr_o), 640'(exp_q[0].addr));
                    chk("wr_strb", 640'(bus.wr_strb_o), 640'(exp_q[0].strb));
                    chk("wr_data", 640'(bus.wr_data_o), 640'(exp_q[0].data));
                    exp_q.delete(0);
                end
                t = cyc + int'($urandom_range(rd_min, rd_max));
                if (t <= last_sched) t = last_sched + 1;
                resp_q.push_back(t);
                last_sched = t;
            end

            if (prev_both) chk("outstanding", 640'(dut.r_outstanding), 640'(model_out));
            resp_counts = resp && (model_out > 0);
            model_out   = model_out + (hs ? 1 : 0) - (resp_counts ? 1 : 0);
            prev_both   = hs && resp;
            if (prev_both) n_both++;
            if (resp) last_resp_cyc = cyc;

            if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                acc_cnt++;
                acc_cyc = cyc;
            end

            if (bus.done_o) begin
                done_cnt++;
                if (cur_nw > 0) chk("done_after_resp", 640'(cyc - last_resp_cyc), 640'(1));
                else            chk("done_no_writes", 640'(cyc - acc_cyc), 640'(2));
            end
        end
    end

    task automatic run_cmd(input logic op, input logic [63:0] addr, input int nl,
                           input logic md_en, input logic [63:0] md_addr,
                           input logic ptr_zero, input logic stall_i,
                           input int dmin, input int dmax, input logic hold_valid);
        logic [511:0] line, t512;
        logic [399:0] md;
        logic [95:0]  ptrs;
        wr_t          e;
        int d0, a0, n;
        stall  = stall_i;
        rd_min = dmin;
        rd_max = dmax;
        t512 = rnd512();
        md   = t512[399:0];
        t512 = rnd512();
        ptrs = ptr_zero ? 96'h0 : t512[95:0];
        if (op == 1'b0) begin
            for (int k = 0; k < nl; k++) begin
                line   = rnd512();
                e.addr = (addr & ~64'h3F) + 64'(k) * 64'd64;
                e.data = line;
                e.strb = '1;
                exp_q.push_back(e);
                dat_q.push_back(line);
            end
        end
        if (op == 1'b1 || md_en) begin
            e.addr = md_addr;
            e.data = {16'h0, md, ptrs};
            e.strb = op ? 64'h3FFF_FFFF_FFFF_F000 : 64'h3FFF_FFFF_FFFF_FFFF;
            exp_q.push_back(e);
        end
        cur_nw = exp_q.size();
        hs_cnt = 0;
        wr_addr_log.delete();
        d0 = done_cnt;
        a0 = acc_cnt;
        @(posedge clk);
        #1;
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_op_i      = op;
        bus.cmd_addr_i    = addr;
        bus.cmd_nlines_i  = 7'(nl);
        bus.cmd_md_en_i   = md_en;
        bus.cmd_md_addr_i = md_addr;
        bus.cmd_md_i      = md;
        bus.cmd_ptrs_i    = ptrs;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        #1;
        if (hold_valid) begin
            t512 = rnd512();
            bus.cmd_op_i     = t512[0];
            bus.cmd_addr_i   = t512[127:64];
            bus.cmd_nlines_i = t512[38:32];
            bus.cmd_md_en_i  = t512[1];
        end else begin
            bus.cmd_valid_i = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("done_count", 640'(done_cnt), 640'(d0 + 1));
        chk("accepts", 640'(acc_cnt), 640'(a0 + 1));
        chk("writes", 640'(hs_cnt), 640'(cur_nw));
        chk("exp_left", 640'(exp_q.size()), 640'(0));
        chk("done_single", 640'(bus.done_o), 640'(0));
        chk("idle_after", 640'({bus.busy_o, bus.cmd_ready_o, bus.err_o}), 640'(3'b010));
    endtask

    initial begin
        int d0, n;
        rst = 1'b1;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_op_i      = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_nlines_i  = '0;
        bus.cmd_md_en_i   = 1'b0;
        bus.cmd_md_addr_i = '0;
        bus.cmd_md_i      = '0;
        bus.cmd_ptrs_i    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 640'({bus.wr_valid_o, bus.dat_ready_o, bus.done_o, bus.busy_o, bus.err_o}), 640'(0));
        chk("rst_wr", 640'({bus.wr_addr_o, bus.wr_strb_o}), 640'(0));
        chk("rst_wdata", 640'(bus.wr_data_o), 640'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 640'(bus.cmd_ready_o), 640'(1));

        // Full 64-line burst with metadata, responses 3 cycles after each write.
        run_cmd(1'b0, 64'h1000, 64, 1'b1, 64'h8000, 1'b0, 1'b0, 3, 3, 1'b0);
        chk("burst_first", 640'(wr_addr_log[0]), 640'(64'h1000));
        chk("burst_line63", 640'(wr_addr_log[63]), 640'(64'h1FC0));
        chk("burst_md_addr", 640'(wr_addr_log[64]), 640'(64'h8000));

        run_cmd(1'b1, 64'h0, 0, 1'b0, 64'h2000, 1'b1, 1'b0, 2, 2, 1'b0);
        chk("md_only_low96", 640'(last_wdata[95:0]), 640'(0));

        // Short burst under random stalls; cmd_valid stays high while busy.
        run_cmd(1'b0, 64'h3010, 4, 1'b0, 64'h0, 1'b0, 1'b1, 1, 4, 1'b1);

        run_cmd(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 2, 1'b0, 64'h0, 1'b0, 1'b0, 2, 2, 1'b0);
        chk("wrap_addr", 640'(wr_addr_log[1]), 640'(64'h0));

        run_cmd(1'b0, 64'h4000, 0, 1'b0, 64'h0, 1'b0, 1'b0, 1, 1, 1'b0);

        // Response delay of 1 makes every response coincide with the next write handshake.
        n_both = 0;
        run_cmd(1'b0, 64'h5000, 8, 1'b0, 64'h0, 1'b0, 1'b0, 1, 1, 1'b0);
        chk("same_cycle_seen", 640'(n_both > 6), 640'(1));

        for (int i = 0; i < 6; i++) begin
            logic [63:0] ra, rm;
            ra = {$urandom, $urandom};
            rm = {$urandom, $urandom};
            run_cmd(1'($urandom_range(0, 3) == 0), ra, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), rm, 1'b0, 1'b1, 1, 5, 1'b0);
        end

        // Reset in the middle of an 8-line burst.
        stall = 1'b0; rd_min = 3; rd_max = 3;
        d0 = done_cnt;
        begin
            logic [511:0] l;
            wr_t e;
            for (int k = 0; k < 8; k++) begin
                l = rnd512();
                e.addr = 64'h6000 + 64'(k) * 64'd64;
                e.data = l;
                e.strb = '1;
                exp_q.push_back(e);
                dat_q.push_back(l);
            end
        end
        cur_nw = 9;
        hs_cnt = 0;
        @(posedge clk); #1;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_op_i     = 1'b0;
        bus.cmd_addr_i   = 64'h6000;
        bus.cmd_nlines_i = 7'd8;
        bus.cmd_md_en_i  = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while (hs_cnt < 2 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("rst_mid_beats", 640'(hs_cnt), 640'(2));
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        dat_q.delete();
        model_out = 0;
        @(negedge clk);
        chk("rst_mid_ctl", 640'({bus.wr_valid_o, bus.dat_ready_o, bus.done_o, bus.busy_o}), 640'(0));
        chk("rst_mid_wr", 640'({bus.wr_addr_o, bus.wr_strb_o}), 640'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rel_ctl", 640'({bus.wr_valid_o, bus.busy_o, bus.cmd_ready_o, bus.err_o}), 640'(4'b0010));
        n = 0;
        while (!bus.err_o && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("late_resp_err", 640'(bus.err_o), 640'(1));
        repeat (5) @(negedge clk);
        #1;
        chk("err_sticky", 640'(bus.err_o), 640'(1));
        chk("rst_no_done", 640'(done_cnt), 640'(d0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
